// File: rtl/arch_map_table.sv
`default_nettype none
// ============================================================================
// Module      : arch_map_table
// Description : Committed (architectural) logical-to-physical register map.
//               It records the mappings of retiring instructions, returns each
//               superseded physical register to the free list, and streams the
//               map out four entries per cycle on recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module arch_map_table #(
    parameter int NUM_LOG = 32,
    parameter int LOG_W   = 5,
    parameter int PHYS_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commitValid0_i,
    input  logic              commitValid1_i,
    input  logic              commitValid2_i,
    input  logic              commitValid3_i,
    input  logic [LOG_W-1:0]  commitLogDest0_i,
    input  logic [LOG_W-1:0]  commitLogDest1_i,
    input  logic [LOG_W-1:0]  commitLogDest2_i,
    input  logic [LOG_W-1:0]  commitLogDest3_i,
    input  logic [PHYS_W-1:0] commitPhyDest0_i,
    input  logic [PHYS_W-1:0] commitPhyDest1_i,
    input  logic [PHYS_W-1:0] commitPhyDest2_i,
    input  logic [PHYS_W-1:0] commitPhyDest3_i,
    input  logic              recoverFlag_i,
    output logic              freedValid0_o,
    output logic              freedValid1_o,
    output logic              freedValid2_o,
    output logic              freedValid3_o,
    output logic [PHYS_W-1:0] freedReg0_o,
    output logic [PHYS_W-1:0] freedReg1_o,
    output logic [PHYS_W-1:0] freedReg2_o,
    output logic [PHYS_W-1:0] freedReg3_o,
    output logic              recoverBusy_o,
    output logic              recoverValid_o,
    output logic [LOG_W-1:0]  recoverIdx_o,
    output logic [PHYS_W-1:0] recoverMap0_o,
    output logic [PHYS_W-1:0] recoverMap1_o,
    output logic [PHYS_W-1:0] recoverMap2_o,
    output logic [PHYS_W-1:0] recoverMap3_o
);

    localparam int             CNT_W    = LOG_W - 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_LOG / 4 - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    // Commit lanes gathered into arrays, lane 0 oldest in program order
    logic [3:0]        w_cvalid;
    logic [LOG_W-1:0]  w_clog [4];
    logic [PHYS_W-1:0] w_cphy [4];

    assign w_cvalid  = {commitValid3_i, commitValid2_i, commitValid1_i, commitValid0_i};
    assign w_clog[0] = commitLogDest0_i;
    assign w_clog[1] = commitLogDest1_i;
    assign w_clog[2] = commitLogDest2_i;
    assign w_clog[3] = commitLogDest3_i;
    assign w_cphy[0] = commitPhyDest0_i;
    assign w_cphy[1] = commitPhyDest1_i;
    assign w_cphy[2] = commitPhyDest2_i;
    assign w_cphy[3] = commitPhyDest3_i;

    logic [PHYS_W-1:0] table_q [NUM_LOG];
    logic [PHYS_W-1:0] table_d [NUM_LOG];
    logic [PHYS_W-1:0] w_freed [4];
    logic [PHYS_W-1:0] freed_reg_q [4];
    logic [3:0]        freed_valid_q;
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;

    // Freed register per lane: an older lane in the same group writing the
    // same logical register is the true previous mapping, else the table
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_freed[k] = table_q[w_clog[k]];
            for (int j = 0; j < k; j++) begin
                if (w_cvalid[j] && (w_clog[j] == w_clog[k])) begin
                    w_freed[k] = w_cphy[j];
                end
            end
        end
    end

    // Next table: lanes applied oldest first so the youngest same-L lane wins
    always_comb begin
        for (int i = 0; i < NUM_LOG; i++) begin
            table_d[i] = table_q[i];
        end
        for (int k = 0; k < 4; k++) begin
            if (w_cvalid[k]) begin
                table_d[w_clog[k]] = w_cphy[k];
            end
        end
    end

    // Map storage, identity mapping out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOG; i++) begin
                table_q[i] <= PHYS_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_LOG; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // Freed outputs, lane aligned with the commit one cycle earlier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freed_valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                freed_reg_q[k] <= '0;
            end
        end else begin
            freed_valid_q <= w_cvalid;
            for (int k = 0; k < 4; k++) begin
                freed_reg_q[k] <= w_cvalid[k] ? w_freed[k] : '0;
            end
        end
    end

    // Recovery FSM: a recover request (re)starts a dump of NUM_LOG/4 cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            if (recoverFlag_i) begin
                state_q <= DUMP;
                cnt_q   <= '0;
            end else if (state_q == DUMP) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_q <= IDLE;
                end
            end
        end
    end

    logic              w_dump;
    logic [PHYS_W-1:0] w_map [4];

    assign w_dump = (state_q == DUMP);

    // Dump window reads the registered table, so later commits show up in
    // entries that have not yet been sent
    generate
        for (genvar gk = 0; gk < 4; gk++) begin : g_map
            assign w_map[gk] = w_dump ? table_q[{cnt_q, 2'(gk)}] : '0;
        end
    endgenerate

    assign recoverBusy_o  = w_dump;
    assign recoverValid_o = w_dump;
    assign recoverIdx_o   = w_dump ? {cnt_q, 2'b00} : '0;
    assign recoverMap0_o  = w_map[0];
    assign recoverMap1_o  = w_map[1];
    assign recoverMap2_o  = w_map[2];
    assign recoverMap3_o  = w_map[3];

    assign freedValid0_o  = freed_valid_q[0];
    assign freedValid1_o  = freed_valid_q[1];
    assign freedValid2_o  = freed_valid_q[2];
    assign freedValid3_o  = freed_valid_q[3];
    assign freedReg0_o    = freed_reg_q[0];
    assign freedReg1_o    = freed_reg_q[1];
    assign freedReg2_o    = freed_reg_q[2];
    assign freedReg3_o    = freed_reg_q[3];

endmodule
`default_nettype wire

// File: tb/tb_arch_map_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_arch_map_table
// Description : Directed, table-driven bench for arch_map_table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arch_map_table;

    localparam int NUM_LOG = 32;
    localparam int LOG_W   = 5;
    localparam int PHYS_W  = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] cv = '0;
    logic [3:0][LOG_W-1:0] cl = '0;
    logic [3:0][PHYS_W-1:0] cp = '0;
    logic recoverFlag = 1'b0;

    logic fv0, fv1, fv2, fv3;
    logic [PHYS_W-1:0] fr0, fr1, fr2, fr3;
    logic busy, rvalid;
    logic [LOG_W-1:0] ridx;
    logic [PHYS_W-1:0] rm0, rm1, rm2, rm3;

    arch_map_table #(.NUM_LOG(NUM_LOG), .LOG_W(LOG_W), .PHYS_W(PHYS_W)) dut (
        .clk(clk), .reset(reset),
        .commitValid0_i(cv[0]), .commitValid1_i(cv[1]),
        .commitValid2_i(cv[2]), .commitValid3_i(cv[3]),
        .commitLogDest0_i(cl[0]), .commitLogDest1_i(cl[1]),
        .commitLogDest2_i(cl[2]), .commitLogDest3_i(cl[3]),
        .commitPhyDest0_i(cp[0]), .commitPhyDest1_i(cp[1]),
        .commitPhyDest2_i(cp[2]), .commitPhyDest3_i(cp[3]),
        .recoverFlag_i(recoverFlag),
        .freedValid0_o(fv0), .freedValid1_o(fv1),
        .freedValid2_o(fv2), .freedValid3_o(fv3),
        .freedReg0_o(fr0), .freedReg1_o(fr1),
        .freedReg2_o(fr2), .freedReg3_o(fr3),
        .recoverBusy_o(busy), .recoverValid_o(rvalid), .recoverIdx_o(ridx),
        .recoverMap0_o(rm0), .recoverMap1_o(rm1),
        .recoverMap2_o(rm2), .recoverMap3_o(rm3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]              v;
        logic [3:0][LOG_W-1:0]   l;
        logic [3:0][PHYS_W-1:0]  p;
        logic [3:0]              ev;
        logic [3:0][PHYS_W-1:0]  er;
    } vec_t;

    vec_t vecs [6];
    int   exp_tbl [NUM_LOG];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v,
                                input int l0, input int l1, input int l2, input int l3,
                                input int p0, input int p1, input int p2, input int p3,
                                input logic [3:0] ev,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t r;
        r.v  = v;
        r.l  = {LOG_W'(l3), LOG_W'(l2), LOG_W'(l1), LOG_W'(l0)};
        r.p  = {PHYS_W'(p3), PHYS_W'(p2), PHYS_W'(p1), PHYS_W'(p0)};
        r.ev = ev;
        r.er = {PHYS_W'(e3), PHYS_W'(e2), PHYS_W'(e1), PHYS_W'(e0)};
        return r;
    endfunction

    task automatic check_freed(input string tag, input logic [3:0] ev,
                               input logic [3:0][PHYS_W-1:0] er);
        chk($sformatf("%s fv0", tag), 32'(fv0), 32'(ev[0]));
        chk($sformatf("%s fv1", tag), 32'(fv1), 32'(ev[1]));
        chk($sformatf("%s fv2", tag), 32'(fv2), 32'(ev[2]));
        chk($sformatf("%s fv3", tag), 32'(fv3), 32'(ev[3]));
        chk($sformatf("%s fr0", tag), 32'(fr0), 32'(er[0]));
        chk($sformatf("%s fr1", tag), 32'(fr1), 32'(er[1]));
        chk($sformatf("%s fr2", tag), 32'(fr2), 32'(er[2]));
        chk($sformatf("%s fr3", tag), 32'(fr3), 32'(er[3]));
    endtask

    task automatic check_idle(input string tag);
        chk($sformatf("%s busy", tag), 32'(busy), 0);
        chk($sformatf("%s valid", tag), 32'(rvalid), 0);
        chk($sformatf("%s idx", tag), 32'(ridx), 0);
        chk($sformatf("%s map0", tag), 32'(rm0), 0);
        chk($sformatf("%s map3", tag), 32'(rm3), 0);
    endtask

    task automatic check_dump_cycle(input int c);
        chk($sformatf("dump%0d busy", c), 32'(busy), 1);
        chk($sformatf("dump%0d valid", c), 32'(rvalid), 1);
        chk($sformatf("dump%0d idx", c), 32'(ridx), 32'(4 * c));
        chk($sformatf("dump%0d map0", c), 32'(rm0), 32'(exp_tbl[4 * c + 0]));
        chk($sformatf("dump%0d map1", c), 32'(rm1), 32'(exp_tbl[4 * c + 1]));
        chk($sformatf("dump%0d map2", c), 32'(rm2), 32'(exp_tbl[4 * c + 2]));
        chk($sformatf("dump%0d map3", c), 32'(rm3), 32'(exp_tbl[4 * c + 3]));
    endtask

    // Full dump; optionally a commit of L=2/P=90 and L=30/P=91 during the
    // cnt == commit_at cycle, and optionally a restart at cnt == restart_at
    task automatic do_dump(input int commit_at, input int restart_at);
        int rs;
        rs = restart_at;
        recoverFlag = 1'b1;
        tick();
        recoverFlag = 1'b0;
        for (int c = 0; c < NUM_LOG / 4; c++) begin
            check_dump_cycle(c);
            if (c == rs) begin
                recoverFlag = 1'b1;
                tick();
                recoverFlag = 1'b0;
                rs = -1;
                c  = -1;
            end else if (c == commit_at) begin
                cv = 4'b0011;
                cl = {LOG_W'(0), LOG_W'(0), LOG_W'(30), LOG_W'(2)};
                cp = {PHYS_W'(0), PHYS_W'(0), PHYS_W'(91), PHYS_W'(90)};
                tick();
                cv = '0;
                check_freed("dumpcommit", 4'b0011,
                            {PHYS_W'(0), PHYS_W'(0), PHYS_W'(30), PHYS_W'(71)});
                exp_tbl[2]  = 90;
                exp_tbl[30] = 91;
            end else begin
                if (c == 7 && commit_at >= 0) begin
                    chk("dump entry30", 32'(rm2), 91);
                end
                tick();
            end
        end
        check_idle("post dump");
    endtask

    initial begin
        for (int i = 0; i < NUM_LOG; i++) exp_tbl[i] = i;

        vecs[0] = mk(4'b0001, 5, 0, 0, 0, 40, 0, 0, 0, 4'b0001, 5, 0, 0, 0);
        vecs[1] = mk(4'b1011, 7, 7, 7, 7, 50, 51, 99, 52, 4'b1011, 7, 50, 0, 51);
        vecs[2] = mk(4'b1111, 1, 2, 3, 4, 60, 61, 62, 63, 4'b1111, 1, 2, 3, 4);
        vecs[3] = mk(4'b1111, 1, 2, 3, 4, 70, 71, 72, 73, 4'b1111, 60, 61, 62, 63);
        vecs[4] = mk(4'b0000, 9, 9, 9, 9, 5, 5, 5, 5, 4'b0000, 0, 0, 0, 0);
        vecs[5] = mk(4'b0111, 0, 5, 5, 5, 80, 41, 42, 43, 4'b0111, 0, 40, 41, 0);

        // Reset state
        #12;
        check_idle("reset");
        check_freed("reset", 4'b0000, '0);
        reset = 1'b0;
        tick();
        check_idle("after reset");

        // Identity dump
        do_dump(-1, -1);

        // Commit vectors, back to back
        for (int n = 0; n < 6; n++) begin
            cv = vecs[n].v;
            cl = vecs[n].l;
            cp = vecs[n].p;
            tick();
            check_freed($sformatf("vec%0d", n), vecs[n].ev, vecs[n].er);
            for (int k = 0; k < 4; k++) begin
                if (vecs[n].v[k]) exp_tbl[vecs[n].l[k]] = int'(vecs[n].p[k]);
            end
        end
        cv = '0;
        tick();
        check_freed("idle group", 4'b0000, '0);

        // Dump reflecting the commits
        do_dump(-1, -1);

        // Commit during dump at cnt=1
        do_dump(1, -1);

        // Restart at cnt=3
        do_dump(-1, 3);

        // Reset mid-dump, between clock edges
        recoverFlag = 1'b1;
        tick();
        recoverFlag = 1'b0;
        tick();
        tick();
        chk("middump busy", 32'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async reset");
        check_freed("async reset", 4'b0000, '0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_LOG; i++) exp_tbl[i] = i;
        tick();
        do_dump(-1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
